funct_generator_sched: RTL and testbench

- Sequences the function generator datapath: configures it, paces its sample production at a programmable rate, and stops after a programmed burst length.
- Sits between the host/control registers and the generator; its outputs drive the generator's `enh_conf_i`, `en_low_i`, `sel_i` and `amp_i` inputs.
- Throttles against the downstream FIFO's full flag so that no sample is issued while the FIFO is full.

---
 rtl/funct_generator_sched_if.sv | 42 ++++
 rtl/funct_generator_sched.sv | 167 ++++++++++++++++
 tb/tb_funct_generator_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/funct_generator_sched_if.sv
// Bundle of the control, configuration and generator-side signals of
// funct_generator_sched. The master side is the host/control logic
// (plus the downstream FIFO flag); the slave side is the scheduler.
interface funct_generator_sched_if #(
  parameter int INT_BITS  = 8,
  parameter int DIV_WIDTH = 16,
  parameter int LEN_WIDTH = 16
);
  logic                 start_i;
  logic                 stop_i;
  logic                 cfg_req_i;
  logic [1:0]           cfg_sel_i;
  logic [INT_BITS-1:0]  cfg_amp_i;
  logic [DIV_WIDTH-1:0] cfg_div_i;
  logic [LEN_WIDTH-1:0] cfg_len_i;
  logic                 fifo_full_i;

  logic                 gen_enh_conf_o;
  logic                 gen_en_low_o;
  logic [1:0]           gen_sel_o;
  logic [INT_BITS-1:0]  gen_amp_o;
  logic                 sample_stb_o;
  logic [LEN_WIDTH-1:0] sample_cnt_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 cfg_rej_o;
  logic                 timeout_o;

  modport master (
    output start_i, stop_i, cfg_req_i, cfg_sel_i, cfg_amp_i, cfg_div_i,
           cfg_len_i, fifo_full_i,
    input  gen_enh_conf_o, gen_en_low_o, gen_sel_o, gen_amp_o, sample_stb_o,
           sample_cnt_o, busy_o, done_o, cfg_rej_o, timeout_o
  );

  modport slave (
    input  start_i, stop_i, cfg_req_i, cfg_sel_i, cfg_amp_i, cfg_div_i,
           cfg_len_i, fifo_full_i,
    output gen_enh_conf_o, gen_en_low_o, gen_sel_o, gen_amp_o, sample_stb_o,
           sample_cnt_o, busy_o, done_o, cfg_rej_o, timeout_o
  );
endinterface

// File: rtl/funct_generator_sched.sv
// funct_generator_sched: configures the function generator, paces sample
// production at div+1 cycles per sample, throttles on FIFO full and stops
// after a programmed burst length (len = 0 runs until stopped).
// Optional macro SCHED_WATCHDOG_EN: aborts a stall lasting STALL_LIMIT cycles
// with a timeout_o pulse alongside done_o.
//
// state  | meaning
// IDLE   | waiting for cfg_req_i or start_i
// CONFIG | two-cycle configuration window, gen_enh_conf_o high
// RUN    | divider counting, sample issued on each tick
// STALL  | tick pending while the FIFO is full
// DONE   | one-cycle end-of-burst, done_o high
module funct_generator_sched #(
  parameter int INT_BITS    = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int LEN_WIDTH   = 16,
  parameter int STALL_LIMIT = 1024
) (
  input logic clk,
  input logic rst,
  funct_generator_sched_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CONFIG, RUN, STALL, DONE} state_t;

  state_t               state_q, state_d;
  logic                 cfg_phase_q;
  logic [1:0]           sel_q;
  logic [INT_BITS-1:0]  amp_q;
  logic [DIV_WIDTH-1:0] div_q, div_cnt_q;
  logic [LEN_WIDTH-1:0] len_q, cnt_q, cnt_inc;
  logic                 enh_q, busy_q, done_q, rej_q;
  logic                 tick, last, issue, wd_fire;

  assign tick    = (div_cnt_q == '0);
  assign cnt_inc = cnt_q + 1'b1;
  // The sample being issued this cycle is the final one of a bounded burst.
  assign last    = (len_q != '0) && (cnt_inc == len_q);

`ifdef SCHED_WATCHDOG_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);
  logic [SW-1:0] stall_cnt_q;
  logic          timeout_q;

  // Stall counter: zero outside STALL, so it is clear on every STALL entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= (state_q == STALL) ? stall_cnt_q + 1'b1 : '0;
      timeout_q   <= wd_fire;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  logic [31:0] unused_stall_limit;
  assign unused_stall_limit = STALL_LIMIT;
  assign bus.timeout_o      = 1'b0;
`endif

  // Next-state decode plus the combinational sample-issue decision.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    wd_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_req_i)    state_d = CONFIG;
        else if (bus.start_i) state_d = RUN;
      end
      CONFIG: begin
        if (cfg_phase_q) state_d = IDLE;
      end
      RUN: begin
        if (bus.stop_i) begin
          state_d = DONE;
        end else if (tick) begin
          if (bus.fifo_full_i) begin
            state_d = STALL;
          end else begin
            issue = 1'b1;
            if (last) state_d = DONE;
          end
        end
      end
      STALL: begin
        if (bus.stop_i) begin
          state_d = DONE;
        end else if (!bus.fifo_full_i) begin
          issue   = 1'b1;
          state_d = last ? DONE : RUN;
        end
`ifdef SCHED_WATCHDOG_EN
        else if (stall_cnt_q == SW'(STALL_LIMIT - 1)) begin
          wd_fire = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_phase_q <= 1'b0;
      enh_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rej_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_phase_q <= (state_q == CONFIG) && !cfg_phase_q;
      enh_q       <= (state_d == CONFIG);
      busy_q      <= (state_d == RUN) || (state_d == STALL);
      done_q      <= (state_d == DONE);
      rej_q       <= bus.cfg_req_i && (state_q != IDLE);
    end
  end

  // Shadow configuration registers, loaded only from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
      amp_q <= '0;
      div_q <= '0;
      len_q <= '0;
    end else if (state_q == IDLE && bus.cfg_req_i) begin
      sel_q <= bus.cfg_sel_i;
      amp_q <= bus.cfg_amp_i;
      div_q <= bus.cfg_div_i;
      len_q <= bus.cfg_len_i;
    end
  end

  // Rate divider and sample counter; the divider holds while stalled or stopping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      cnt_q     <= '0;
    end else if (state_q == IDLE && !bus.cfg_req_i && bus.start_i) begin
      div_cnt_q <= '0;
      cnt_q     <= '0;
    end else if (issue) begin
      div_cnt_q <= div_q;
      cnt_q     <= cnt_inc;
    end else if (state_q == RUN && !bus.stop_i && !tick) begin
      div_cnt_q <= div_cnt_q - 1'b1;
    end
  end

  assign bus.gen_enh_conf_o = enh_q;
  assign bus.gen_en_low_o   = !issue;
  assign bus.sample_stb_o   = issue;
  assign bus.gen_sel_o      = sel_q;
  assign bus.gen_amp_o      = amp_q;
  assign bus.sample_cnt_o   = cnt_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.cfg_rej_o      = rej_q;

endmodule

// File: tb/tb_funct_generator_sched.sv
// Scoreboard bench for funct_generator_sched: stimulus tasks queue the
// expected strobe/done/reject/config events with their cycle numbers, and a
// negedge monitor pops and compares whenever the DUT presents one.
module tb_funct_generator_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  typedef struct {
    int          cyc;
    logic [31:0] val;
    logic        flag;
  } ev_t;

  ev_t q_stb[$];
  ev_t q_done[$];
  ev_t q_rej[$];
  ev_t q_conf[$];
  ev_t e_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  funct_generator_sched_if #(.INT_BITS(8), .DIV_WIDTH(16), .LEN_WIDTH(16)) bus ();

  funct_generator_sched #(
    .INT_BITS(8), .DIV_WIDTH(16), .LEN_WIDTH(16), .STALL_LIMIT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic ev_t mk(input int c, input logic [31:0] v, input logic f);
    ev_t e;
    e.cyc = c; e.val = v; e.flag = f;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic bad(input string name, input int c);
    n_checks++;
    $display("FAIL %s: event presence wrong at cycle %0d", name, c);
  endtask

  // Monitor: flag overdue expectations, then match every presented event.
  always @(negedge clk) begin
    if (!rst) begin
      if (q_stb.size() > 0 && q_stb[0].cyc < cyc) begin bad("stb_missing", q_stb[0].cyc); void'(q_stb.pop_front()); end
      if (q_done.size() > 0 && q_done[0].cyc < cyc) begin bad("done_missing", q_done[0].cyc); void'(q_done.pop_front()); end
      if (q_rej.size() > 0 && q_rej[0].cyc < cyc) begin bad("rej_missing", q_rej[0].cyc); void'(q_rej.pop_front()); end
      if (q_conf.size() > 0 && q_conf[0].cyc < cyc) begin bad("conf_missing", q_conf[0].cyc); void'(q_conf.pop_front()); end
      if (bus.sample_stb_o) begin
        if (q_stb.size() == 0) bad("stb_unexpected", cyc);
        else begin
          e_m = q_stb.pop_front();
          chk("stb_cycle", cyc, e_m.cyc);
          chk("stb_count", bus.sample_cnt_o, e_m.val);
          chk("stb_en_low", bus.gen_en_low_o, 1'b0);
        end
      end
      if (bus.done_o) begin
        if (q_done.size() == 0) bad("done_unexpected", cyc);
        else begin
          e_m = q_done.pop_front();
          chk("done_cycle", cyc, e_m.cyc);
          chk("done_count", bus.sample_cnt_o, e_m.val);
          chk("done_timeout", bus.timeout_o, e_m.flag);
        end
      end else if (bus.timeout_o) bad("timeout_without_done", cyc);
      if (bus.cfg_rej_o) begin
        if (q_rej.size() == 0) bad("rej_unexpected", cyc);
        else begin
          e_m = q_rej.pop_front();
          chk("rej_cycle", cyc, e_m.cyc);
        end
      end
      if (bus.gen_enh_conf_o) begin
        if (q_conf.size() == 0) bad("conf_unexpected", cyc);
        else begin
          e_m = q_conf.pop_front();
          chk("conf_cycle", cyc, e_m.cyc);
          chk("conf_sel_amp", {bus.gen_sel_o, bus.gen_amp_o}, e_m.val);
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_cfg(input logic [1:0] sel, input logic [7:0] amp,
                        input logic [15:0] dv, input logic [15:0] ln);
    int c0;
    @(posedge clk); #1;
    c0 = cyc;
    q_conf.push_back(mk(c0 + 1, {sel, amp}, 1'b0));
    q_conf.push_back(mk(c0 + 2, {sel, amp}, 1'b0));
    bus.cfg_req_i = 1'b1;
    bus.cfg_sel_i = sel;
    bus.cfg_amp_i = amp;
    bus.cfg_div_i = dv;
    bus.cfg_len_i = ln;
    @(posedge clk); #1;
    bus.cfg_req_i = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic burst(input int dv, input int n, input bit with_done, output int base);
    @(posedge clk); #1;
    base = cyc;
    for (int i = 0; i < n; i++) q_stb.push_back(mk(base + 1 + i * (dv + 1), i, 1'b0));
    if (with_done) q_done.push_back(mk(base + 1 + (n - 1) * (dv + 1) + 1, n, 1'b0));
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int b;
    int c0;
    bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.cfg_req_i = 1'b0;
    bus.cfg_sel_i = '0; bus.cfg_amp_i = '0; bus.cfg_div_i = '0; bus.cfg_len_i = '0;
    bus.fifo_full_i = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en_low", bus.gen_en_low_o, 1'b1);
    chk("rst_stb", bus.sample_stb_o, 1'b0);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_done", bus.done_o, 1'b0);
    chk("rst_cnt", bus.sample_cnt_o, 16'd0);
    chk("rst_sel_amp", {bus.gen_sel_o, bus.gen_amp_o}, 10'd0);
    chk("rst_enh", bus.gen_enh_conf_o, 1'b0);
    chk("rst_rej_to", {bus.cfg_rej_o, bus.timeout_o}, 2'b00);
    rst = 1'b0;

    // Configure and burst: div=3, len=4.
    do_cfg(2'd2, 8'd5, 16'd3, 16'd4);
    burst(3, 4, 1'b1, b);
    wait_until(b + 2);
    chk("t1_busy_run", bus.busy_o, 1'b1);
    wait_until(b + 16);
    chk("t1_busy_after", bus.busy_o, 1'b0);
    chk("t1_cnt_hold", bus.sample_cnt_o, 16'd4);
    chk("t1_sel_amp", {bus.gen_sel_o, bus.gen_amp_o}, {2'd2, 8'd5});

    // Back-pressure: div=0, len=8, full for 5 cycles after the 3rd strobe.
    do_cfg(2'd1, 8'h10, 16'd0, 16'd8);
    burst(0, 3, 1'b0, b);
    wait_until(b + 4);
    bus.fifo_full_i = 1'b1;
    for (int i = 0; i < 5; i++) q_stb.push_back(mk(b + 9 + i, 3 + i, 1'b0));
    q_done.push_back(mk(b + 14, 8, 1'b0));
    wait_until(b + 6);
    chk("t2_busy_stall", bus.busy_o, 1'b1);
    chk("t2_en_low_stall", bus.gen_en_low_o, 1'b1);
    wait_until(b + 9);
    bus.fifo_full_i = 1'b0;
    wait_until(b + 16);

    // Abort: len=0, div=1, stop on the tick after 10 samples.
    do_cfg(2'd0, 8'h22, 16'd1, 16'd0);
    burst(1, 10, 1'b0, b);
    wait_until(b + 21);
    bus.stop_i = 1'b1;
    q_done.push_back(mk(b + 22, 10, 1'b0));
    wait_until(b + 22);
    bus.stop_i = 1'b0;
    wait_until(b + 24);
    chk("t3_cnt_hold", bus.sample_cnt_o, 16'd10);

    // Rejected configuration during RUN.
    do_cfg(2'd1, 8'hFD, 16'd2, 16'd3);
    burst(2, 3, 1'b1, b);
    wait_until(b + 2);
    q_rej.push_back(mk(b + 3, 0, 1'b0));
    bus.cfg_req_i = 1'b1;
    bus.cfg_sel_i = 2'd0;
    bus.cfg_amp_i = 8'd7;
    bus.cfg_div_i = 16'd5;
    bus.cfg_len_i = 16'd9;
    wait_until(b + 3);
    bus.cfg_req_i = 1'b0;
    wait_until(b + 10);
    chk("t4_amp_kept", bus.gen_amp_o, 8'hFD);
    chk("t4_sel_kept", bus.gen_sel_o, 2'd1);

    // Simultaneous cfg_req and start in IDLE: configuration wins.
    @(posedge clk); #1;
    c0 = cyc;
    q_conf.push_back(mk(c0 + 1, {2'd3, 8'h80}, 1'b0));
    q_conf.push_back(mk(c0 + 2, {2'd3, 8'h80}, 1'b0));
    bus.cfg_req_i = 1'b1; bus.start_i = 1'b1;
    bus.cfg_sel_i = 2'd3; bus.cfg_amp_i = 8'h80;
    bus.cfg_div_i = 16'd2; bus.cfg_len_i = 16'd0;
    @(posedge clk); #1;
    bus.cfg_req_i = 1'b0; bus.start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_busy_low", bus.busy_o, 1'b0);
      @(posedge clk); #1;
    end

    // Reset in the middle of a continuous burst (div=2).
    burst(2, 2, 1'b0, b);
    wait_until(b + 5);
    rst = 1'b1;
    #1;
    chk("t6_en_low", bus.gen_en_low_o, 1'b1);
    chk("t6_busy", bus.busy_o, 1'b0);
    chk("t6_cnt", bus.sample_cnt_o, 16'd0);
    chk("t6_sel_amp", {bus.gen_sel_o, bus.gen_amp_o}, 10'd0);
    chk("t6_done", bus.done_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

`ifdef SCHED_WATCHDOG_EN
    // Held FIFO full: 16 stall cycles then timeout with done.
    burst(0, 1, 1'b0, b);
    wait_until(b + 2);
    bus.fifo_full_i = 1'b1;
    q_done.push_back(mk(b + 19, 1, 1'b1));
    wait_until(b + 20);
    bus.fifo_full_i = 1'b0;
    wait_until(b + 22);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("end_stb_q_empty", q_stb.size(), 0);
    chk("end_done_q_empty", q_done.size(), 0);
    chk("end_rej_q_empty", q_rej.size(), 0);
    chk("end_conf_q_empty", q_conf.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
